snake_body_walker: RTL

Controller and coordinate walker for the snake body direction shift register. It owns the register's shift enable, which drives the clock-gate enable for the register clock, and its serial input. It turns game commands (push head, pop tail, scan body) into register shifts, and tracks head, tail and length. During a scan it rotates the register through one full revolution and streams the grid coordinate of every body cell, flagging a hit against a query cell. It sits between the game-tick logic and the shift register.

---
 rtl/snake_pkg.sv | 28 ++
 rtl/snake_step.sv | 32 +++
 rtl/snake_body_walker.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body walker: direction and
// command encodings, controller states and the reset cell.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_PX = 2'b00,
      DIR_PY = 2'b01,
      DIR_NX = 2'b10,
      DIR_NY = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      OP_PUSH = 2'b00,
      OP_POP  = 2'b01,
      OP_SCAN = 2'b10,
      OP_NOP  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DONE
   } state_t;

   localparam int SNAKE_HEAD_X0 = 8;
   localparam int SNAKE_HEAD_Y0 = 7;

endpackage

// File: rtl/snake_step.sv
// One grid step from (x,y) in direction dir, wrapping at the grid edges.
module snake_step
   import snake_pkg::*;
#(
   parameter int GRID_W = 16,
   parameter int GRID_H = 15,
   parameter int X_BITS = $clog2(GRID_W),
   parameter int Y_BITS = $clog2(GRID_H)
) (
   input  logic [X_BITS-1:0] x,
   input  logic [Y_BITS-1:0] y,
   input  logic [1:0]        dir,
   output logic [X_BITS-1:0] nx,
   output logic [Y_BITS-1:0] ny
);

   localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_W - 1);
   localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(GRID_H - 1);

   always_comb begin
      nx = x;
      ny = y;
      case (dir_t'(dir))
         DIR_PX:  nx = (x == X_MAX) ? '0 : x + X_BITS'(1);
         DIR_NX:  nx = (x == '0) ? X_MAX : x - X_BITS'(1);
         DIR_PY:  ny = (y == Y_MAX) ? '0 : y + Y_BITS'(1);
         DIR_NY:  ny = (y == '0) ? Y_MAX : y - Y_BITS'(1);
         default: ;
      endcase
   end

endmodule

// File: rtl/snake_body_walker.sv
// Snake body controller: turns push/pop/scan commands into direction shift
// register shifts, tracks head/tail/length and streams body cells on a scan.
module snake_body_walker
   import snake_pkg::*;
#(
   parameter int WIDTH    = 2,
   parameter int DEPTH    = 234,
   parameter int GRID_W   = 16,
   parameter int GRID_H   = 15,
   parameter int X_BITS   = $clog2(GRID_W),
   parameter int Y_BITS   = $clog2(GRID_H),
   parameter int LEN_BITS = $clog2(DEPTH + 1),
   parameter int HEAD_X0  = SNAKE_HEAD_X0,
   parameter int HEAD_Y0  = SNAKE_HEAD_Y0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [WIDTH-1:0]    cmd_dir,
   input  logic [X_BITS-1:0]   query_x,
   input  logic [Y_BITS-1:0]   query_y,
   output logic                sr_shift,
   output logic [WIDTH-1:0]    sr_in,
   input  logic [WIDTH-1:0]    sr_out,
   output logic [X_BITS-1:0]   head_x,
   output logic [Y_BITS-1:0]   head_y,
   output logic [X_BITS-1:0]   tail_x,
   output logic [Y_BITS-1:0]   tail_y,
   output logic [LEN_BITS-1:0] length,
   output logic                seg_valid,
   output logic [X_BITS-1:0]   seg_x,
   output logic [Y_BITS-1:0]   seg_y,
   output logic                scan_done,
   output logic                hit,
   output logic                scan_err,
   output logic                err
);

   localparam logic [LEN_BITS-1:0] DEPTH_L = LEN_BITS'(DEPTH);

   state_t              state;
   logic [LEN_BITS-1:0] cnt;
   logic [X_BITS-1:0]   pos_x;
   logic [Y_BITS-1:0]   pos_y;
   dir_t                tail_dir;
   logic                tail_dir_valid;
   logic                hit_acc;

   logic                accept;
   op_t                 op;
   logic                full;
   logic                push_ok;
   logic                can_pop;
   logic                is_pop;
   logic                link;
   logic                seg_match;
   logic [X_BITS-1:0]   upd_x_in;
   logic [Y_BITS-1:0]   upd_y_in;
   logic [1:0]          upd_dir;
   logic [X_BITS-1:0]   upd_x;
   logic [Y_BITS-1:0]   upd_y;
   logic [X_BITS-1:0]   walk_x;
   logic [Y_BITS-1:0]   walk_y;
   logic [X_BITS-1:0]   fin_x;
   logic [Y_BITS-1:0]   fin_y;

   assign accept    = cmd_valid && (state == ST_IDLE);
   assign op        = op_t'(cmd_op);
   assign full      = (length == DEPTH_L);
   assign push_ok   = accept && (op == OP_PUSH) && !full;
   assign can_pop   = (length != '0) && tail_dir_valid;
   assign is_pop    = (op == OP_POP);
   // Only the last `length` stages of a full revolution hold live links.
   assign link      = (state == ST_SCAN) && (cnt >= DEPTH_L - length);
   assign seg_match = (pos_x == query_x) && (pos_y == query_y);

   // The register shifts on an accepted push or on every scan cycle (rotate).
   assign sr_shift  = push_ok || (state == ST_SCAN);
   assign sr_in     = (state == ST_SCAN) ? sr_out : cmd_dir;

   assign upd_x_in  = is_pop ? tail_x : head_x;
   assign upd_y_in  = is_pop ? tail_y : head_y;
   assign upd_dir   = is_pop ? tail_dir : cmd_dir;

   snake_step #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .X_BITS (X_BITS),
      .Y_BITS (Y_BITS)
   ) u_step_ends (
      .x   (upd_x_in),
      .y   (upd_y_in),
      .dir (upd_dir),
      .nx  (upd_x),
      .ny  (upd_y)
   );

   snake_step #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .X_BITS (X_BITS),
      .Y_BITS (Y_BITS)
   ) u_step_walk (
      .x   (pos_x),
      .y   (pos_y),
      .dir (sr_out),
      .nx  (walk_x),
      .ny  (walk_y)
   );

   assign fin_x = link ? walk_x : pos_x;
   assign fin_y = link ? walk_y : pos_y;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         cmd_ready      <= 1'b1;
         head_x         <= X_BITS'(HEAD_X0);
         head_y         <= Y_BITS'(HEAD_Y0);
         tail_x         <= X_BITS'(HEAD_X0);
         tail_y         <= Y_BITS'(HEAD_Y0);
         length         <= '0;
         cnt            <= '0;
         pos_x          <= '0;
         pos_y          <= '0;
         tail_dir       <= DIR_PX;
         tail_dir_valid <= 1'b0;
         hit_acc        <= 1'b0;
         seg_valid      <= 1'b0;
         seg_x          <= '0;
         seg_y          <= '0;
         scan_done      <= 1'b0;
         hit            <= 1'b0;
         scan_err       <= 1'b0;
         err            <= 1'b0;
      end else begin
         err       <= 1'b0;
         seg_valid <= 1'b0;
         scan_done <= 1'b0;
         hit       <= 1'b0;
         scan_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (op)
                     OP_PUSH: begin
                        if (full) begin
                           err <= 1'b1;
                        end else begin
                           head_x <= upd_x;
                           head_y <= upd_y;
                           length <= length + LEN_BITS'(1);
                        end
                     end
                     OP_POP: begin
                        if (can_pop) begin
                           tail_x         <= upd_x;
                           tail_y         <= upd_y;
                           length         <= length - LEN_BITS'(1);
                           tail_dir_valid <= 1'b0;
                        end else begin
                           err <= 1'b1;
                        end
                     end
                     OP_SCAN: begin
                        state     <= ST_SCAN;
                        cmd_ready <= 1'b0;
                        cnt       <= '0;
                        pos_x     <= tail_x;
                        pos_y     <= tail_y;
                        hit_acc   <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            ST_SCAN: begin
               cnt <= cnt + LEN_BITS'(1);
               if (link) begin
                  seg_valid <= 1'b1;
                  seg_x     <= pos_x;
                  seg_y     <= pos_y;
                  pos_x     <= walk_x;
                  pos_y     <= walk_y;
                  if (seg_match) begin
                     hit_acc <= 1'b1;
                  end
                  if (cnt == DEPTH_L - length) begin
                     tail_dir       <= dir_t'(sr_out);
                     tail_dir_valid <= 1'b1;
                  end
               end
               // The walk must land exactly on the head after the last link.
               if (cnt == DEPTH_L - LEN_BITS'(1)) begin
                  state     <= ST_DONE;
                  scan_done <= 1'b1;
                  hit       <= hit_acc || (link && seg_match);
                  scan_err  <= (fin_x != head_x) || (fin_y != head_y);
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
